// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the jacaranda PC/interrupt sequencer: level widths,
// return-stack entry layout {addr, flag, prio} and the per-cycle action code.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_NORMAL  = 2'd0,
        SEQ_TAKE    = 2'd1,
        SEQ_RET     = 2'd2,
        SEQ_RET_ERR = 2'd3
    } seq_action_e;

    // Levels 0..N_IRQ-1 are channels, N_IRQ is thread level.
    function automatic int prio_width(input int n_irq);
        return $clog2(n_irq + 1);
    endfunction

    // Entry layout, MSB to LSB: addr | flag | prio.
    function automatic int entry_width(input int addr_w, input int n_irq);
        return addr_w + 1 + prio_width(n_irq);
    endfunction

    function automatic int entry_flag_bit(input int n_irq);
        return prio_width(n_irq);
    endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// LIFO of return frames; the pointer and contents clear asynchronously so no
// frame survives a reset taken in the middle of an interrupt.
module ret_stack #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_push_data,
    output logic [WIDTH-1:0] o_top_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   r_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] w_top_idx;

    assign w_top_idx  = r_ptr[PTR_W-1:0] - PTR_W'(1);
    assign o_top_data = r_mem[w_top_idx];
    assign o_full     = (r_ptr == (PTR_W+1)'(DEPTH));
    assign o_empty    = (r_ptr == '0);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_push && !o_full) begin
            r_mem[r_ptr[PTR_W-1:0]] <= i_push_data;
            r_ptr                   <= r_ptr + (PTR_W+1)'(1);
        end else if (i_pop && !o_empty) begin
            r_ptr <= r_ptr - (PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with N prioritised, nestable interrupt channels; each take
// saves {next address, flag, level} on a hardware return stack.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int N_IRQ       = 4,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_PC    = 0
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       jmp_en,
    input  logic                       je_en,
    input  logic                       ret,
    input  logic [ADDR_W-1:0]          target,
    input  logic                       flag_w_en,
    input  logic                       flag_in,
    input  logic [N_IRQ-1:0]           int_req,
    input  logic [N_IRQ-1:0]           int_en,
    input  logic [N_IRQ*ADDR_W-1:0]    int_vec,
    output logic [ADDR_W-1:0]          pc,
    output logic                       flag,
    output logic [N_IRQ-1:0]           int_ack,
    output logic                       in_isr,
    output logic [$clog2(N_IRQ+1)-1:0] cur_prio,
    output logic                       stack_err
);
    localparam int PRIO_W  = prio_width(N_IRQ);
    localparam int ENTRY_W = entry_width(ADDR_W, N_IRQ);
    localparam int FLAG_B  = entry_flag_bit(N_IRQ);

    logic [ADDR_W-1:0]  r_pc;
    logic               r_flag;
    logic [N_IRQ-1:0]   r_int_ack;
    logic [PRIO_W-1:0]  r_cur_prio;
    logic               r_stack_err;

    logic [PRIO_W-1:0]  w_cand;
    logic [ADDR_W-1:0]  w_nsa;
    logic [ADDR_W-1:0]  w_vec;
    logic [N_IRQ-1:0]   w_ack;
    logic               w_take;
    logic               w_full;
    logic               w_empty;
    logic [ENTRY_W-1:0] w_top;
    seq_action_e        w_action;

    // Returns N_IRQ (thread level) when nothing is pending, so the strict
    // comparison against the current level alone decides whether to take.
    function automatic logic [PRIO_W-1:0] pick_channel(input logic [N_IRQ-1:0] v);
        pick_channel = PRIO_W'(N_IRQ);
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (v[i]) pick_channel = PRIO_W'(i);
        end
    endfunction

    assign w_cand = pick_channel(int_req & int_en);
    assign w_take = (w_cand < r_cur_prio) && !w_full && !ret;
    assign w_nsa  = (jmp_en || (je_en && r_flag)) ? target : r_pc + ADDR_W'(1);

    always_comb begin
        w_vec = '0;
        w_ack = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (w_cand == PRIO_W'(i)) begin
                w_vec    = int_vec[i*ADDR_W +: ADDR_W];
                w_ack[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_action = SEQ_NORMAL;
        if (ret)         w_action = w_empty ? SEQ_RET_ERR : SEQ_RET;
        else if (w_take) w_action = SEQ_TAKE;
    end

    ret_stack #(
        .WIDTH (ENTRY_W),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clock       (clock),
        .rst_n       (rst_n),
        .i_push      (w_action == SEQ_TAKE),
        .i_pop       (w_action == SEQ_RET),
        .i_push_data ({w_nsa, r_flag, r_cur_prio}),
        .o_top_data  (w_top),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= ADDR_W'(RESET_PC);
            r_flag      <= 1'b0;
            r_int_ack   <= '0;
            r_cur_prio  <= PRIO_W'(N_IRQ);
            r_stack_err <= 1'b0;
        end else begin
            r_int_ack <= '0;
            case (w_action)
                SEQ_RET: begin
                    r_pc       <= w_top[ENTRY_W-1 -: ADDR_W];
                    r_flag     <= w_top[FLAG_B];
                    r_cur_prio <= w_top[PRIO_W-1:0];
                end
                SEQ_RET_ERR: begin
                    r_pc        <= r_pc + ADDR_W'(1);
                    r_stack_err <= 1'b1;
                end
                // Flag holds: the pushed copy is the pre-cycle value.
                SEQ_TAKE: begin
                    r_pc       <= w_vec;
                    r_cur_prio <= w_cand;
                    r_int_ack  <= w_ack;
                end
                default: begin
                    r_pc <= w_nsa;
                    if (je_en)          r_flag <= 1'b0;
                    else if (flag_w_en) r_flag <= flag_in;
                end
            endcase
        end
    end

    assign pc        = r_pc;
    assign flag      = r_flag;
    assign int_ack   = r_int_ack;
    assign in_isr    = !w_empty;
    assign cur_prio  = r_cur_prio;
    assign stack_err = r_stack_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: default instance plus an 8-channel instance
// used where a full stack must coexist with a higher-priority request.
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        jmp_en, je_en, ret, flag_w_en, flag_in;
    logic [7:0]  target;
    logic [3:0]  int_req, int_en;
    logic [31:0] int_vec;
    logic [7:0]  pc;
    logic        flag, in_isr, stack_err;
    logic [3:0]  int_ack;
    logic [2:0]  cur_prio;

    logic [7:0]  int_req_w, int_en_w;
    logic [63:0] int_vec_w;
    logic [7:0]  pc_w;
    logic        flag_w, in_isr_w, stack_err_w;
    logic [7:0]  int_ack_w;
    logic [3:0]  cur_prio_w;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    pc_sequencer dut (
        .clock(clock), .rst_n(rst_n), .jmp_en(jmp_en), .je_en(je_en), .ret(ret),
        .target(target), .flag_w_en(flag_w_en), .flag_in(flag_in),
        .int_req(int_req), .int_en(int_en), .int_vec(int_vec),
        .pc(pc), .flag(flag), .int_ack(int_ack), .in_isr(in_isr),
        .cur_prio(cur_prio), .stack_err(stack_err)
    );

    pc_sequencer #(.ADDR_W(8), .N_IRQ(8), .STACK_DEPTH(4), .RESET_PC(0)) dut_w (
        .clock(clock), .rst_n(rst_n), .jmp_en(jmp_en), .je_en(je_en), .ret(ret),
        .target(target), .flag_w_en(flag_w_en), .flag_in(flag_in),
        .int_req(int_req_w), .int_en(int_en_w), .int_vec(int_vec_w),
        .pc(pc_w), .flag(flag_w), .int_ack(int_ack_w), .in_isr(in_isr_w),
        .cur_prio(cur_prio_w), .stack_err(stack_err_w)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; jmp_en = 0; je_en = 0; ret = 0; flag_w_en = 0; flag_in = 0;
        target = 8'h00; int_req = 4'h0; int_en = 4'hF;
        int_vec = {8'hD0, 8'hC0, 8'hB0, 8'hA0};
        int_req_w = 8'h00; int_en_w = 8'hFF;
        int_vec_w = {8'h90, 8'h80, 8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20};
        tick();
        tick();
        n_tests++; if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h exp 00", pc); end
        n_tests++; if (flag !== 1'b0) begin n_fail++; $display("FAIL reset_flag: got %b exp 0", flag); end
        n_tests++; if (int_ack !== 4'h0) begin n_fail++; $display("FAIL reset_ack: got %b exp 0000", int_ack); end
        n_tests++; if (cur_prio !== 3'd4) begin n_fail++; $display("FAIL reset_prio: got %0d exp 4", cur_prio); end
        n_tests++; if (in_isr !== 1'b0) begin n_fail++; $display("FAIL reset_in_isr: got %b exp 0", in_isr); end
        n_tests++; if (stack_err !== 1'b0) begin n_fail++; $display("FAIL reset_stack_err: got %b exp 0", stack_err); end
        rst_n = 1'b1;
    endtask

    task automatic test_count_wrap();
        logic [7:0] exp_pc;
        for (int i = 1; i <= 256; i++) begin
            tick();
            exp_pc = 8'(i);
            n_tests++;
            if (pc !== exp_pc) begin n_fail++; $display("FAIL count_pc[%0d]: got %h exp %h", i, pc, exp_pc); end
        end
        n_tests++; if (flag !== 1'b0) begin n_fail++; $display("FAIL count_flag: got %b exp 0", flag); end
        n_tests++; if (int_ack !== 4'h0) begin n_fail++; $display("FAIL count_ack: got %b exp 0000", int_ack); end
    endtask

    task automatic test_branch();
        je_en = 1; target = 8'h40;
        tick();
        n_tests++; if (pc !== 8'h01) begin n_fail++; $display("FAIL je_not_taken_pc: got %h exp 01", pc); end
        je_en = 0; flag_w_en = 1; flag_in = 1;
        tick();
        n_tests++; if (flag !== 1'b1) begin n_fail++; $display("FAIL flag_load: got %b exp 1", flag); end
        n_tests++; if (pc !== 8'h02) begin n_fail++; $display("FAIL flag_load_pc: got %h exp 02", pc); end
        flag_w_en = 0; je_en = 1;
        tick();
        n_tests++; if (pc !== 8'h40) begin n_fail++; $display("FAIL je_taken_pc: got %h exp 40", pc); end
        n_tests++; if (flag !== 1'b0) begin n_fail++; $display("FAIL je_clears_flag: got %b exp 0", flag); end
        je_en = 0; jmp_en = 1; target = 8'h80;
        tick();
        n_tests++; if (pc !== 8'h80) begin n_fail++; $display("FAIL jmp_pc: got %h exp 80", pc); end
        jmp_en = 0;
    endtask

    task automatic test_single_irq();
        jmp_en = 1; target = 8'h0F; flag_w_en = 1; flag_in = 1;
        tick();
        jmp_en = 0; flag_w_en = 0;
        tick();
        n_tests++; if (pc !== 8'h10) begin n_fail++; $display("FAIL irq_setup_pc: got %h exp 10", pc); end
        int_req = 4'b0100;
        tick();
        int_req = 4'b0000;
        n_tests++; if (pc !== 8'hC0) begin n_fail++; $display("FAIL irq_vec_pc: got %h exp C0", pc); end
        n_tests++; if (int_ack !== 4'b0100) begin n_fail++; $display("FAIL irq_ack: got %b exp 0100", int_ack); end
        n_tests++; if (cur_prio !== 3'd2) begin n_fail++; $display("FAIL irq_prio: got %0d exp 2", cur_prio); end
        n_tests++; if (in_isr !== 1'b1) begin n_fail++; $display("FAIL irq_in_isr: got %b exp 1", in_isr); end
        flag_w_en = 1; flag_in = 0;
        tick();
        flag_w_en = 0;
        n_tests++; if (int_ack !== 4'b0000) begin n_fail++; $display("FAIL irq_ack_pulse: got %b exp 0000", int_ack); end
        n_tests++; if (flag !== 1'b0) begin n_fail++; $display("FAIL isr_flag_write: got %b exp 0", flag); end
        ret = 1;
        tick();
        ret = 0;
        n_tests++; if (pc !== 8'h11) begin n_fail++; $display("FAIL ret_pc: got %h exp 11", pc); end
        n_tests++; if (cur_prio !== 3'd4) begin n_fail++; $display("FAIL ret_prio: got %0d exp 4", cur_prio); end
        n_tests++; if (flag !== 1'b1) begin n_fail++; $display("FAIL ret_flag: got %b exp 1", flag); end
        n_tests++; if (in_isr !== 1'b0) begin n_fail++; $display("FAIL ret_in_isr: got %b exp 0", in_isr); end
    endtask

    task automatic test_nesting();
        int_req = 4'b0100;
        tick();
        int_req = 4'b1000;
        tick();
        n_tests++; if (int_ack !== 4'b0000) begin n_fail++; $display("FAIL low_blocked_ack: got %b exp 0000", int_ack); end
        n_tests++; if (pc !== 8'hC1) begin n_fail++; $display("FAIL low_blocked_pc: got %h exp C1", pc); end
        int_req = 4'b1001;
        tick();
        n_tests++; if (pc !== 8'hA0) begin n_fail++; $display("FAIL preempt_pc: got %h exp A0", pc); end
        n_tests++; if (int_ack !== 4'b0001) begin n_fail++; $display("FAIL preempt_ack: got %b exp 0001", int_ack); end
        n_tests++; if (cur_prio !== 3'd0) begin n_fail++; $display("FAIL preempt_prio: got %0d exp 0", cur_prio); end
        int_req = 4'b1000;
        tick();
        ret = 1;
        tick();
        ret = 0;
        n_tests++; if (pc !== 8'hC2) begin n_fail++; $display("FAIL nest_ret1_pc: got %h exp C2", pc); end
        n_tests++; if (cur_prio !== 3'd2) begin n_fail++; $display("FAIL nest_ret1_prio: got %0d exp 2", cur_prio); end
        tick();
        n_tests++; if (int_ack !== 4'b0000) begin n_fail++; $display("FAIL low_still_blocked: got %b exp 0000", int_ack); end
        n_tests++; if (pc !== 8'hC3) begin n_fail++; $display("FAIL nest_isr_pc: got %h exp C3", pc); end
        ret = 1;
        tick();
        ret = 0;
        n_tests++; if (pc !== 8'h12) begin n_fail++; $display("FAIL nest_ret2_pc: got %h exp 12", pc); end
        n_tests++; if (cur_prio !== 3'd4) begin n_fail++; $display("FAIL nest_ret2_prio: got %0d exp 4", cur_prio); end
        tick();
        int_req = 4'b0000;
        n_tests++; if (pc !== 8'hD0) begin n_fail++; $display("FAIL low_taken_pc: got %h exp D0", pc); end
        n_tests++; if (int_ack !== 4'b1000) begin n_fail++; $display("FAIL low_taken_ack: got %b exp 1000", int_ack); end
        ret = 1;
        tick();
        ret = 0;
        n_tests++; if (pc !== 8'h13) begin n_fail++; $display("FAIL low_ret_pc: got %h exp 13", pc); end
    endtask

    task automatic test_jmp_take();
        jmp_en = 1; je_en = 1; target = 8'h55; flag_w_en = 1; flag_in = 0; int_req = 4'b0010;
        tick();
        jmp_en = 0; je_en = 0; flag_w_en = 0; int_req = 4'b0000;
        n_tests++; if (pc !== 8'hB0) begin n_fail++; $display("FAIL jt_vec_pc: got %h exp B0", pc); end
        n_tests++; if (int_ack !== 4'b0010) begin n_fail++; $display("FAIL jt_ack: got %b exp 0010", int_ack); end
        n_tests++; if (flag !== 1'b1) begin n_fail++; $display("FAIL jt_flag_kept: got %b exp 1", flag); end
        ret = 1;
        tick();
        ret = 0;
        n_tests++; if (pc !== 8'h55) begin n_fail++; $display("FAIL jt_ret_pc: got %h exp 55", pc); end
        n_tests++; if (flag !== 1'b1) begin n_fail++; $display("FAIL jt_ret_flag: got %b exp 1", flag); end
        n_tests++; if (cur_prio !== 3'd4) begin n_fail++; $display("FAIL jt_ret_prio: got %0d exp 4", cur_prio); end
    endtask

    task automatic test_stack_full();
        do_reset();
        int_req_w = 8'h10; tick();
        n_tests++; if (pc_w !== 8'h60) begin n_fail++; $display("FAIL full_l1_pc: got %h exp 60", pc_w); end
        int_req_w = 8'h08; tick();
        int_req_w = 8'h04; tick();
        int_req_w = 8'h02; tick();
        n_tests++; if (pc_w !== 8'h30) begin n_fail++; $display("FAIL full_l4_pc: got %h exp 30", pc_w); end
        n_tests++; if (cur_prio_w !== 4'd1) begin n_fail++; $display("FAIL full_l4_prio: got %0d exp 1", cur_prio_w); end
        int_req_w = 8'h01; tick();
        n_tests++; if (int_ack_w !== 8'h00) begin n_fail++; $display("FAIL full_deferred_ack: got %h exp 00", int_ack_w); end
        n_tests++; if (pc_w !== 8'h31) begin n_fail++; $display("FAIL full_deferred_pc: got %h exp 31", pc_w); end
        tick();
        n_tests++; if (int_ack_w !== 8'h00) begin n_fail++; $display("FAIL full_still_deferred: got %h exp 00", int_ack_w); end
        ret = 1; tick(); ret = 0;
        n_tests++; if (pc_w !== 8'h41) begin n_fail++; $display("FAIL full_ret_pc: got %h exp 41", pc_w); end
        n_tests++; if (cur_prio_w !== 4'd2) begin n_fail++; $display("FAIL full_ret_prio: got %0d exp 2", cur_prio_w); end
        n_tests++; if (int_ack_w !== 8'h00) begin n_fail++; $display("FAIL full_ret_no_ack: got %h exp 00", int_ack_w); end
        tick();
        int_req_w = 8'h00;
        n_tests++; if (pc_w !== 8'h20) begin n_fail++; $display("FAIL full_after_ret_pc: got %h exp 20", pc_w); end
        n_tests++; if (int_ack_w !== 8'h01) begin n_fail++; $display("FAIL full_after_ret_ack: got %h exp 01", int_ack_w); end
    endtask

    task automatic test_ret_empty();
        do_reset();
        n_tests++; if (stack_err !== 1'b0) begin n_fail++; $display("FAIL empty_pre_err: got %b exp 0", stack_err); end
        jmp_en = 1; target = 8'h70; tick(); jmp_en = 0;
        ret = 1; tick(); ret = 0;
        n_tests++; if (pc !== 8'h71) begin n_fail++; $display("FAIL empty_ret_pc: got %h exp 71", pc); end
        n_tests++; if (stack_err !== 1'b1) begin n_fail++; $display("FAIL empty_ret_err: got %b exp 1", stack_err); end
        n_tests++; if (cur_prio !== 3'd4) begin n_fail++; $display("FAIL empty_ret_prio: got %0d exp 4", cur_prio); end
        tick();
        n_tests++; if (stack_err !== 1'b1) begin n_fail++; $display("FAIL empty_err_sticky: got %b exp 1", stack_err); end
        n_tests++; if (pc !== 8'h72) begin n_fail++; $display("FAIL empty_after_pc: got %h exp 72", pc); end
    endtask

    task automatic test_async_reset();
        int_req = 4'b0100; tick(); int_req = 4'b0000;
        n_tests++; if (in_isr !== 1'b1) begin n_fail++; $display("FAIL ar_pre_in_isr: got %b exp 1", in_isr); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (pc !== 8'h00) begin n_fail++; $display("FAIL ar_pc: got %h exp 00", pc); end
        n_tests++; if (in_isr !== 1'b0) begin n_fail++; $display("FAIL ar_in_isr: got %b exp 0", in_isr); end
        n_tests++; if (cur_prio !== 3'd4) begin n_fail++; $display("FAIL ar_prio: got %0d exp 4", cur_prio); end
        n_tests++; if (stack_err !== 1'b0) begin n_fail++; $display("FAIL ar_err: got %b exp 0", stack_err); end
        tick();
        rst_n = 1'b1;
        ret = 1; tick(); ret = 0;
        n_tests++; if (pc !== 8'h01) begin n_fail++; $display("FAIL ar_stale_pc: got %h exp 01", pc); end
        n_tests++; if (stack_err !== 1'b1) begin n_fail++; $display("FAIL ar_stale_err: got %b exp 1", stack_err); end
    endtask

    initial begin
        test_reset();
        test_count_wrap();
        test_branch();
        test_single_irq();
        test_nesting();
        test_jmp_take();
        test_stack_full();
        test_ret_empty();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter and interrupt sequencer for the jacaranda core family. It generalises the single-request, single-level interrupt handling of the first-generation core into N prioritised interrupt channels with per-channel vectors, nested preemption, and a hardware return stack. The stack saves the return address, flag and priority level. It sits between the main controller (branch/return strobes), the ALU (flag source) and the instruction memory address port.

## Interface
- `ADDR_W`, 8: PC / branch target / vector width.
- `N_IRQ`, 4: interrupt channel count; channel 0 has the highest priority.
- `STACK_DEPTH`, 4: maximum interrupt nesting depth (power of two, ≥2).
- `RESET_PC`, 0: PC value after reset.

- `clock`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `jmp_en`  in  1: unconditional jump this cycle.
- `je_en`  in  1: conditional jump, taken if `flag`=1.
- `ret`  in  1: return from interrupt.
- `target`  in  ADDR_W: branch target (rs data).
- `flag_w_en`  in  1: load flag from `flag_in`.
- `flag_in`  in  1: ALU flag result.
- `int_req`  in  N_IRQ: level-sensitive requests.
- `int_en`  in  N_IRQ: per-channel enable mask.
- `int_vec`  in  N_IRQ*ADDR_W: vector of channel i at bits [i*ADDR_W +: ADDR_W].
- `pc`  out  ADDR_W: current PC.
- `flag`  out  1: condition flag.
- `int_ack`  out  N_IRQ: one-hot, one-cycle acknowledge of the taken channel.
- `in_isr`  out  1: stack non-empty.
- `cur_prio`  out  $clog2(N_IRQ+1): active level; value N_IRQ means thread level.
- `stack_err`  out  1: sticky, set on `ret` with an empty stack.

## Operation
- Reset values: `pc`=RESET_PC, `flag`=0, `int_ack`=0, `cur_prio`=N_IRQ, stack pointer=0 (`in_isr`=0), `stack_err`=0.
- Candidate: lowest index i with `int_req[i] & int_en[i]`.
- Take condition: a candidate exists, i < `cur_prio` (strictly higher priority), the stack is not full, and `ret`=0.
- Next-sequential address (`nsa`):
  - `target` if `jmp_en`.
  - `target` if `je_en & flag`.
  - `pc+1` otherwise, modulo 2^ADDR_W, wrapping from all-ones to 0.
- Priority per cycle, first match wins:
  1. `ret`: pop the stack. `pc`, `flag` and `cur_prio` are restored from the popped entry. All other strobes are ignored that cycle. If the stack is empty: `pc`←`pc+1`, `stack_err`←1, and no other state changes.
  2. Take: push {`nsa`, `flag`, `cur_prio`}. `pc`←vector[i], `cur_prio`←i, `int_ack[i]` pulses. The flag that is pushed is the pre-cycle `flag`; any `flag_w_en` or `je_en` in the same cycle is discarded.
  3. Normal: `pc`←`nsa`.
     - Flag: if `je_en`, `flag`←0.
     - Else if `flag_w_en`, `flag`←`flag_in`.
     - Otherwise `flag` holds.
- Stack full with a higher-priority request pending: the request is deferred with no ack, and is taken after the next `ret` frees a slot.
- Equal- or lower-priority requests wait until `cur_prio` drops, i.e. after a `ret`.
- Requests stay level-sensitive. The source must deassert within one cycle of its ack, or it is re-taken once the priority allows.

## Timing
- All outputs are registered.
- Request asserted, and take condition true, in cycle n: `pc`=vector and `int_ack` high in cycle n+1.
- `int_ack` is high for exactly one cycle per take.
- `ret` in cycle n: the restored `pc` is visible in cycle n+1. A pending request is evaluated against the restored `cur_prio` from cycle n+1 onward.
- Reset asserted mid-ISR clears the stack immediately (asynchronously). No stale entry survives.
- Push and pop never occur in the same cycle.

## Structure
- Shared package: `PRIO_W = $clog2(N_IRQ+1)` and the stack-entry layout {addr, flag, prio}, so the debug/trace logic can decode entries.
- Sub-module `ret_stack`: a LIFO of STACK_DEPTH entries with push/pop, full/empty flags and an async-reset pointer.
- Priority encoder is a local function.

## Test plan
- Reset, no strobes: `pc` runs 0,1,…,255,0; `flag`=0; `int_ack`=0.
- Branch and flag:
  - `je_en` with `flag`=0: `pc`=pc+1.
  - `je_en` with `flag`=1: `pc`=`target`=0x40, then `flag`=0.
  - `jmp_en` with `target`=0x80: `pc`=0x80.
- Single interrupt:
  - Setup: `int_req[2]`, `int_en`=0xF, `int_vec[2]`=0xC0, at `pc`=0x10.
  - Response: `pc`=0xC0, `int_ack`=0b0100, `cur_prio`=2.
  - Then `ret`: `pc`=0x11, `cur_prio`=4, flag restored.
- Nesting and blocking:
  - In ISR 2, `int_req[0]` asserted: preempts to `int_vec[0]`.
  - In ISR 2, `int_req[3]` asserted: ignored until both `ret`s complete.
- Jump coincident with take: take during `jmp_en` with `target`=0x55 pushes 0x55; `ret` returns to 0x55.
- Stack limits:
  - Stack full (4 nested levels) with a higher-priority request: no ack; taken one cycle after the next `ret`.
  - `ret` on an empty stack: `stack_err`=1.
  - Async reset mid-ISR: `pc`=0, `in_isr`=0.
